// File: rtl/muldiv_ctrl_pkg.sv
// Shared opcode definitions and helpers for the iterative multiply/divide unit.
package muldiv_ctrl_pkg;

    localparam int ALUOP_WIDTH = 5;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MUL  = 5'd15;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_DIV  = 5'd16;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_DIVU = 5'd17;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_REM  = 5'd18;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_REMU = 5'd19;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_t;

    function automatic logic is_muldiv(input logic [ALUOP_WIDTH-1:0] op);
        return (op >= ALUOP_MUL) && (op <= ALUOP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [ALUOP_WIDTH-1:0] op);
        return (op == ALUOP_DIV) || (op == ALUOP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            mode,
    input  logic [XLEN-1:0] acc_in,
    input  logic [XLEN-1:0] work_in,
    input  logic [XLEN-1:0] opnd_in,
    output logic [XLEN-1:0] acc_out,
    output logic [XLEN-1:0] work_out,
    output logic [XLEN-1:0] opnd_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        // The remainder stays below the divisor, so one extra bit holds the shifted value.
        shifted  = {acc_in, work_in[XLEN-1]};
        diff     = shifted - {1'b0, opnd_in};
        acc_out  = acc_in;
        work_out = work_in;
        opnd_out = opnd_in;
        if (mode == STEP_DIV) begin
            if (!diff[XLEN]) begin
                acc_out  = diff[XLEN-1:0];
                work_out = {work_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out  = shifted[XLEN-1:0];
                work_out = {work_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out  = acc_in + (work_in[0] ? opnd_in : '0);
            work_out = work_in >> 1;
            opnd_out = opnd_in << 1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide controller: one radix-2 step per cycle, with
// divide-by-zero, signed-overflow and unknown-opcode results resolved at accept.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ALUOP_WIDTH-1:0] aluop,
    input  logic [XLEN-1:0]        src_a,
    input  logic [XLEN-1:0]        src_b,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        result,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                CNT_W     = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [ALUOP_WIDTH-1:0] op_reg, op_next;
    logic [XLEN-1:0]        acc_reg, acc_next;
    logic [XLEN-1:0]        work_reg, work_next;
    logic [XLEN-1:0]        opnd_reg, opnd_next;
    logic                   neg_q_reg, neg_q_next;
    logic                   neg_r_reg, neg_r_next;
    logic [XLEN-1:0]        result_reg, result_next;

    logic [XLEN-1:0] acc_step, work_step, opnd_step;
    logic [XLEN-1:0] quo_fix, rem_fix, calc_result;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            signed_op;
    step_mode_t      step_mode;

    assign step_mode = (op_reg == ALUOP_MUL) ? STEP_MUL : STEP_DIV;

    muldiv_step #(
        .XLEN     (XLEN)
    ) u_step (
        .mode     (step_mode),
        .acc_in   (acc_reg),
        .work_in  (work_reg),
        .opnd_in  (opnd_reg),
        .acc_out  (acc_step),
        .work_out (work_step),
        .opnd_out (opnd_step)
    );

    assign signed_op = is_signed_div(aluop);
    assign a_mag     = src_a[XLEN-1] ? -src_a : src_a;
    assign b_mag     = src_b[XLEN-1] ? -src_b : src_b;

    // Signs are applied to the outputs of the final step so DONE is reached without an extra cycle.
    assign quo_fix = neg_q_reg ? -work_step : work_step;
    assign rem_fix = neg_r_reg ? -acc_step : acc_step;

    always_comb begin
        calc_result = '0;
        case (op_reg)
            ALUOP_MUL:  calc_result = acc_step;
            ALUOP_DIV:  calc_result = quo_fix;
            ALUOP_DIVU: calc_result = work_step;
            ALUOP_REM:  calc_result = rem_fix;
            ALUOP_REMU: calc_result = acc_step;
            default:    calc_result = '0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        acc_next    = acc_reg;
        work_next   = work_reg;
        opnd_next   = opnd_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_next     = aluop;
                    cnt_next    = '0;
                    acc_next    = '0;
                    neg_q_next  = signed_op & (src_a[XLEN-1] ^ src_b[XLEN-1]);
                    neg_r_next  = signed_op & src_a[XLEN-1];
                    result_next = '0;
                    if (!is_muldiv(aluop)) begin
                        state_next = DONE;
                    end else if ((aluop != ALUOP_MUL) && (src_b == '0)) begin
                        state_next  = DONE;
                        result_next = ((aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU)) ? '1 : src_a;
                    end else if (signed_op && (src_a == MOST_NEG) && (&src_b)) begin
                        state_next  = DONE;
                        result_next = (aluop == ALUOP_DIV) ? src_a : '0;
                    end else begin
                        state_next = CALC;
                        if (aluop == ALUOP_MUL) begin
                            work_next = src_b;
                            opnd_next = src_a;
                        end else begin
                            work_next = signed_op ? a_mag : src_a;
                            opnd_next = signed_op ? b_mag : src_b;
                        end
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    acc_next  = acc_step;
                    work_next = work_step;
                    opnd_next = opnd_step;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        state_next  = DONE;
                        result_next = calc_result;
                    end
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            acc_reg    <= '0;
            work_reg   <= '0;
            opnd_reg   <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            acc_reg    <= acc_next;
            work_reg   <= work_next;
            opnd_reg   <= opnd_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = out_valid ? result_reg : '0;

endmodule
